lectura_rtc: RTL and testbench
==============================

Name: lectura_rtc

Overview:
- Read-side bus sequencer for the RTC multiplexed address/data bus; the counterpart to the power-up write (initialisation) sequencer.
- On a start pulse it performs six back-to-back RTC register reads: seconds, minutes, hours, day, month, year.
- Each read is an address phase followed by a data phase. The returned bytes are latched into holding registers for the display/formatting logic, and completion is flagged with a one-cycle pulse.

Parameters:
- T_PH, 4: clock cycles per bus sub-phase (setup, strobe or hold); legal range 1..15.
- W_CNT, 4: width of the sub-phase cycle counter; must satisfy 2^W_CNT > T_PH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  in  1  request a full six-register read; honoured only in IDLE.
- ad_in  in  8  data returned by the RTC on the AD bus.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse when all six registers are updated.
- cs_n  out  1  RTC chip select, active low.
- rd_n  out  1  RTC read strobe, active low.
- wr_n  out  1  RTC write strobe, active low; used for the address strobe.
- a_d  out  1  0 = address cycle, 1 = data cycle.
- ad_out  out  8  address driven on the AD bus.
- ad_oe  out  1  1 = block drives ad_out onto the AD bus.
- seg, min, hora, dia, mes, anio  out  8 each  latched BCD register contents.

Behaviour:
- Reset (reset=0 at a clock edge):
  - State becomes IDLE; register index = 0; cycle counter = 0.
  - cs_n = rd_n = wr_n = 1; a_d = 1; ad_oe = 0; ad_out = 0x00; busy = 0; done = 0.
  - All six data outputs = 0x00.
  - Reset mid-transaction aborts immediately, with no partial latch and no done pulse.
- Address table, fixed by register index 0..5: 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, mapped to seg, min, hora, dia, mes, anio.
- States: IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, FIN.
  - Every state except IDLE and FIN lasts exactly T_PH cycles, using a cycle counter that runs 0..T_PH-1 and clears on each state change.
- IDLE:
  - Outputs as at reset, except the data registers are held.
  - start=1 -> A_SET; index = 0; busy = 1 from the next cycle.
- A_SET: cs_n=0, a_d=0, ad_oe=1, ad_out=table[index], wr_n=1, rd_n=1.
- A_STB: as A_SET but wr_n=0.
- A_HLD: as A_SET with wr_n=1; ad_out stays valid.
- D_SET: cs_n=0, a_d=1, ad_oe=0, rd_n=1.
- D_STB: rd_n=0.
  - ad_in is captured into the register selected by index on the last cycle of D_STB (counter = T_PH-1).
  - The new value is visible on the output the following cycle.
- D_HLD: rd_n=1, cs_n=0.
  - At the end: if index < 5, increment index and go to A_SET.
  - If index = 5, go to FIN.
- FIN (one cycle): cs_n=1, done=1, busy=1; next state IDLE with busy=0.
- Timing:
  - Total latency from start accepted to done = 6 × 6 × T_PH + 1 cycles.
  - With T_PH=4 this is 145 cycles: start sampled at edge 0, done high during cycle 145.
- start is ignored while busy, including in FIN; there is no queuing.
  - A start present in the first IDLE cycle after FIN launches a new sequence.
- Strobe separation: rd_n and wr_n are never low at the same time.
  - ad_oe is 0 in every cycle where rd_n = 0.
- Latched registers are updated only at their own D_STB capture; the other five hold.
- No arithmetic beyond the counters.
  - The index wraps only through the FIN→IDLE path, never past 5.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, keep start=0 for 20 cycles -> cs_n=rd_n=wr_n=1, ad_oe=0, busy=0, done=0, all data outputs 0x00.
- Full read, T_PH=4: RTC model returns 0x45,0x30,0x12,0x26,0x04,0x16 for addresses 0x21..0x26; pulse start -> address sequence 0x21..0x26 in order, each wr_n low pulse exactly 4 cycles; done high exactly at cycle 145 for one cycle; outputs seg=0x45, min=0x30, hora=0x12, dia=0x26, mes=0x04, anio=0x16.
- start held high continuously -> sequences run back to back; done pulses every 146 cycles; no extra bus activity mid-sequence.
- Reset asserted during D_STB of index 3 -> next cycle IDLE, cs_n=1, all outputs 0x00, no done pulse.
- Protocol checker over the full run: rd_n=0 implies ad_oe=0 and a_d=1; wr_n=0 implies a_d=0 and ad_oe=1; rd_n and wr_n never both 0; cs_n=0 throughout each transaction.
- T_PH=1 build: same data as the full-read scenario -> done at cycle 37, identical captured values.

Source files
------------

// File: rtl/lectura_rtc.sv
// lectura_rtc: six-register RTC read sequencer over the multiplexed AD bus
module lectura_rtc #(
    parameter int T_PH  = 4,
    parameter int W_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] ad_in,
    output logic       busy,
    output logic       done,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio
);
    typedef enum logic [2:0] {IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, FIN} state_t;
    localparam logic [W_CNT-1:0] LAST = W_CNT'(T_PH - 1);
    state_t state, next;
    logic [W_CNT-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] regs [6];
    logic [7:0] addr;
    logic last, timed;
    assign timed = state != IDLE && state != FIN;
    assign last  = cnt == LAST;
    // Next-state: each bus sub-phase advances after T_PH cycles, six reads then FIN
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? A_SET : IDLE;
            A_SET:   next = last ? A_STB : A_SET;
            A_STB:   next = last ? A_HLD : A_STB;
            A_HLD:   next = last ? D_SET : A_HLD;
            D_SET:   next = last ? D_STB : D_SET;
            D_STB:   next = last ? D_HLD : D_STB;
            D_HLD:   next = !last ? D_HLD : (idx == 3'd5 ? FIN : A_SET);
            FIN:     next = IDLE;
            default: next = IDLE;
        endcase
    end
    // Bus outputs decoded from state; address table indexed by register slot
    always_comb begin
        addr = idx == 3'd0 ? 8'h21 :
               idx == 3'd1 ? 8'h22 :
               idx == 3'd2 ? 8'h23 :
               idx == 3'd3 ? 8'h24 :
               idx == 3'd4 ? 8'h25 : 8'h26;
        cs_n   = !timed;
        a_d    = !(state inside {A_SET, A_STB, A_HLD});
        ad_oe  = !a_d;
        ad_out = ad_oe ? addr : 8'h00;
        wr_n   = state != A_STB;
        rd_n   = state != D_STB;
        busy   = state != IDLE;
        done   = state == FIN;
    end
    // State, phase counter, register index and captured data
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            for (int i = 0; i < 6; i++) regs[i] <= 8'h00;
        end else begin
            state <= next;
            cnt   <= (next != state || !timed) ? '0 : cnt + 1'b1;
            idx   <= (state == IDLE || state == FIN) ? 3'd0 :
                     (state == D_HLD && last && idx != 3'd5) ? idx + 1'b1 : idx;
            if (state == D_STB && last) regs[idx] <= ad_in;
        end
    end
    assign seg  = regs[0];
    assign min  = regs[1];
    assign hora = regs[2];
    assign dia  = regs[3];
    assign mes  = regs[4];
    assign anio = regs[5];
endmodule

// File: tb/tb_lectura_rtc.sv
// tb_lectura_rtc: directed bench for the RTC read sequencer at T_PH=4 and T_PH=1
module tb_lectura_rtc;
    logic clk = 0, reset = 0, start_a = 0, start_b = 0;
    logic [7:0] ad_in_a, ad_in_b, ra = 8'h00, rb = 8'h00;
    logic busy_a, done_a, cs_n_a, rd_n_a, wr_n_a, a_d_a, ad_oe_a;
    logic busy_b, done_b, cs_n_b, rd_n_b, wr_n_b, a_d_b, ad_oe_b;
    logic [7:0] ad_out_a, seg_a, min_a, hora_a, dia_a, mes_a, anio_a;
    logic [7:0] ad_out_b, seg_b, min_b, hora_b, dia_b, mes_b, anio_b;
    logic [7:0] exp_addr [6] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    lectura_rtc #(.T_PH(4), .W_CNT(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .ad_in(ad_in_a),
        .busy(busy_a), .done(done_a), .cs_n(cs_n_a), .rd_n(rd_n_a), .wr_n(wr_n_a),
        .a_d(a_d_a), .ad_out(ad_out_a), .ad_oe(ad_oe_a),
        .seg(seg_a), .min(min_a), .hora(hora_a), .dia(dia_a), .mes(mes_a), .anio(anio_a));

    lectura_rtc #(.T_PH(1), .W_CNT(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .ad_in(ad_in_b),
        .busy(busy_b), .done(done_b), .cs_n(cs_n_b), .rd_n(rd_n_b), .wr_n(wr_n_b),
        .a_d(a_d_b), .ad_out(ad_out_b), .ad_oe(ad_oe_b),
        .seg(seg_b), .min(min_b), .hora(hora_b), .dia(dia_b), .mes(mes_b), .anio(anio_b));

    function automatic logic [7:0] rtc(input logic [7:0] a);
        case (a)
            8'h21:   return 8'h45;
            8'h22:   return 8'h30;
            8'h23:   return 8'h12;
            8'h24:   return 8'h26;
            8'h25:   return 8'h04;
            8'h26:   return 8'h16;
            default: return 8'hEE;
        endcase
    endfunction

    // RTC model: latch the address while the write strobe is low
    always @(posedge clk) begin
        if (!wr_n_a) ra <= ad_out_a;
        if (!wr_n_b) rb <= ad_out_b;
    end
    assign ad_in_a = rtc(ra);
    assign ad_in_b = rtc(rb);

    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        if ((!rd_n_a && (ad_oe_a || !a_d_a)) || (!wr_n_a && (a_d_a || !ad_oe_a)) ||
            (!rd_n_a && !wr_n_a) || (busy_a && !done_a && cs_n_a)) begin
            errors++;
            $display("FAIL protocol_a: rd_n=%b wr_n=%b a_d=%b ad_oe=%b cs_n=%b busy=%b, required legal strobe combination",
                     rd_n_a, wr_n_a, a_d_a, ad_oe_a, cs_n_a, busy_a);
        end
        checks++;
        if ((!rd_n_b && (ad_oe_b || !a_d_b)) || (!wr_n_b && (a_d_b || !ad_oe_b)) ||
            (!rd_n_b && !wr_n_b) || (busy_b && !done_b && cs_n_b)) begin
            errors++;
            $display("FAIL protocol_b: rd_n=%b wr_n=%b a_d=%b ad_oe=%b cs_n=%b busy=%b, required legal strobe combination",
                     rd_n_b, wr_n_b, a_d_b, ad_oe_b, cs_n_b, busy_b);
        end
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (3) tick();
        reset = 1;
        repeat (20) tick();
        checks++;
        if ({cs_n_a, rd_n_a, wr_n_a, ad_oe_a, busy_a, done_a} !== 6'b111000) begin
            errors++;
            $display("FAIL reset_bus_a: got %b required 111000", {cs_n_a, rd_n_a, wr_n_a, ad_oe_a, busy_a, done_a});
        end
        checks++;
        if ({seg_a, min_a, hora_a, dia_a, mes_a, anio_a} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data_a: got %h required 0", {seg_a, min_a, hora_a, dia_a, mes_a, anio_a});
        end
        checks++;
        if ({cs_n_b, rd_n_b, wr_n_b, ad_oe_b, busy_b, done_b, ad_out_b} !== 14'b111000_00000000) begin
            errors++;
            $display("FAIL reset_bus_b: got %b required 11100000000000", {cs_n_b, rd_n_b, wr_n_b, ad_oe_b, busy_b, done_b, ad_out_b});
        end
        checks++;
        if ({seg_b, min_b, hora_b, dia_b, mes_b, anio_b} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data_b: got %h required 0", {seg_b, min_b, hora_b, dia_b, mes_b, anio_b});
        end
    endtask

    task automatic test_full_read();
        int nd, na, wl;
        logic [7:0] la;
        nd = 0; na = 0; wl = 0; la = 8'h00;
        start_a = 1;
        for (int k = 1; k <= 150; k++) begin
            tick();
            start_a = 0;
            if (done_a) begin
                nd++;
                checks++;
                if (k != 145) begin
                    errors++;
                    $display("FAIL full_done_cycle: got %0d required 145", k);
                end
            end
            if (!wr_n_a) begin
                wl++;
                la = ad_out_a;
            end else if (wl != 0) begin
                checks++;
                if (wl != 4 || na > 5 || la !== exp_addr[na > 5 ? 5 : na]) begin
                    errors++;
                    $display("FAIL full_addr%0d: got addr %h width %0d required addr %h width 4",
                             na, la, wl, exp_addr[na > 5 ? 5 : na]);
                end
                na++;
                wl = 0;
            end
        end
        checks++;
        if (nd != 1 || na != 6) begin
            errors++;
            $display("FAIL full_counts: got done %0d addr %0d required 1 and 6", nd, na);
        end
        checks++;
        if ({seg_a, min_a, hora_a, dia_a, mes_a, anio_a} !== 48'h453012260416) begin
            errors++;
            $display("FAIL full_data: got %h required 453012260416", {seg_a, min_a, hora_a, dia_a, mes_a, anio_a});
        end
    endtask

    task automatic test_tph1();
        int nd, na, wl;
        logic [7:0] la;
        nd = 0; na = 0; wl = 0; la = 8'h00;
        start_b = 1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            start_b = 0;
            if (done_b) begin
                nd++;
                checks++;
                if (k != 37) begin
                    errors++;
                    $display("FAIL tph1_done_cycle: got %0d required 37", k);
                end
            end
            if (!wr_n_b) begin
                wl++;
                la = ad_out_b;
            end else if (wl != 0) begin
                checks++;
                if (wl != 1 || na > 5 || la !== exp_addr[na > 5 ? 5 : na]) begin
                    errors++;
                    $display("FAIL tph1_addr%0d: got addr %h width %0d required addr %h width 1",
                             na, la, wl, exp_addr[na > 5 ? 5 : na]);
                end
                na++;
                wl = 0;
            end
        end
        checks++;
        if (nd != 1 || na != 6) begin
            errors++;
            $display("FAIL tph1_counts: got done %0d addr %0d required 1 and 6", nd, na);
        end
        checks++;
        if ({seg_b, min_b, hora_b, dia_b, mes_b, anio_b} !== 48'h453012260416) begin
            errors++;
            $display("FAIL tph1_data: got %h required 453012260416", {seg_b, min_b, hora_b, dia_b, mes_b, anio_b});
        end
    endtask

    task automatic test_back_to_back();
        int nd, last, nw, want;
        logic prev;
        nd = 0; last = 0; nw = 0; prev = 1;
        start_a = 1;
        for (int k = 1; k <= 500; k++) begin
            tick();
            if (prev && !wr_n_a) nw++;
            prev = wr_n_a;
            if (done_a) begin
                nd++;
                want = nd == 1 ? 145 : last + 146;
                checks++;
                if (k != want) begin
                    errors++;
                    $display("FAIL b2b_done%0d: got cycle %0d required %0d", nd, k, want);
                end
                checks++;
                if (nw != 6) begin
                    errors++;
                    $display("FAIL b2b_strobes%0d: got %0d required 6", nd, nw);
                end
                nw = 0;
                last = k;
                if (nd == 3) begin
                    start_a = 0;
                    break;
                end
            end
        end
        start_a = 0;
        checks++;
        if (nd != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d required 3", nd);
        end
        tick();
        tick();
        checks++;
        if (busy_a !== 1'b0 || cs_n_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: got busy %b cs_n %b required 0 1", busy_a, cs_n_a);
        end
    endtask

    task automatic test_reset_mid();
        int nr, nd, ncs;
        logic prev, found;
        nr = 0; nd = 0; ncs = 0; prev = 1; found = 0;
        start_a = 1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            start_a = 0;
            if (prev && !rd_n_a) nr++;
            prev = rd_n_a;
            if (nr == 4) begin
                found = 1;
                break;
            end
        end
        start_a = 0;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_find_dstb3: got %0d read strobes required 4", nr);
        end
        reset = 0;
        tick();
        reset = 1;
        checks++;
        if (busy_a !== 1'b0 || cs_n_a !== 1'b1 || rd_n_a !== 1'b1 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_idle: got busy %b cs_n %b rd_n %b done %b required 0 1 1 0", busy_a, cs_n_a, rd_n_a, done_a);
        end
        checks++;
        if ({seg_a, min_a, hora_a, dia_a, mes_a, anio_a} !== 48'h0) begin
            errors++;
            $display("FAIL mid_data: got %h required 0", {seg_a, min_a, hora_a, dia_a, mes_a, anio_a});
        end
        repeat (200) begin
            tick();
            if (done_a) nd++;
            if (!cs_n_a) ncs++;
        end
        checks++;
        if (nd != 0 || ncs != 0) begin
            errors++;
            $display("FAIL mid_quiet: got done %0d cs cycles %0d required 0 0", nd, ncs);
        end
    endtask

    initial begin
        test_reset();
        test_full_read();
        test_tph1();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
